// File: rtl/debug_pkg.sv
// Shared opcode map, response defaults and parser state encoding for the
// debug command path.
package debug_pkg;

  localparam logic [7:0] OP_SET_DIV  = 8'h01;
  localparam logic [7:0] OP_SET_CTRL = 8'h02;
  localparam logic [7:0] OP_PULSE    = 8'h03;
  localparam logic [7:0] OP_WR_A     = 8'h10;
  localparam logic [7:0] OP_WR_B     = 8'h11;
  localparam logic [7:0] OP_WR_C     = 8'h12;
  localparam logic [7:0] OP_WR_D     = 8'h13;
  localparam logic [7:0] OP_RD_Y     = 8'h20;
  localparam logic [7:0] OP_RD_Z     = 8'h21;

  localparam logic [7:0] ACK_DEFAULT = 8'hAA;
  localparam logic [7:0] NAK_DEFAULT = 8'hEE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    TGT_DIV,
    TGT_CTRL,
    TGT_OUT
  } target_t;

  // Payload length in bytes for an opcode; 0 means no payload phase.
  function automatic int unsigned payload_len(input logic [7:0] op, input int unsigned nb);
    case (op)
      OP_SET_DIV:                         return 4;
      OP_SET_CTRL:                        return 1;
      OP_WR_A, OP_WR_B, OP_WR_C, OP_WR_D: return nb;
      default:                            return 0;
    endcase
  endfunction

endpackage

// File: rtl/debug_tx_serializer.sv
// Response serializer: holds either one byte or an NB-byte word and emits it
// LSB first over a valid/ready byte stream.
module debug_tx_serializer #(
  parameter int NB = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_word,
  input  logic [NB*8-1:0] word_data,
  input  logic          load_byte,
  input  logic [7:0]    byte_data,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          done
);

  localparam int CW = $clog2(NB + 1);

  logic [NB*8-1:0] data_q, data_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    done    = 1'b0;
    if (valid_q && tx_ready) begin
      data_d = data_q >> 8;
      cnt_d  = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        valid_d = 1'b0;
        done    = 1'b1;
      end
    end
    // Loads are only issued by the parser while nothing is in flight.
    if (load_word) begin
      data_d  = word_data;
      cnt_d   = CW'(NB);
      valid_d = 1'b1;
    end else if (load_byte) begin
      data_d  = {{(NB*8-8){1'b0}}, byte_data};
      cnt_d   = CW'(1);
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign tx_data  = data_q[7:0];
  assign tx_valid = valid_q;

endmodule

// File: rtl/debug_cmd_parser.sv
// Host command decoder: parses opcode + little-endian payload bytes, updates
// the clock-divider controls and debug outputs, and queues ACK/NAK/readback.
module debug_cmd_parser
  import debug_pkg::*;
#(
  parameter int         BUS_WIDTH      = 32,
  parameter int         COUNTER_BITS   = 32,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] ACK            = ACK_DEFAULT,
  parameter logic [7:0] NAK            = NAK_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    option,
  output logic                    out_enable,
  output logic [COUNTER_BITS-1:0] divider,
  output logic                    pulse,
  output logic [BUS_WIDTH-1:0]    output_a,
  output logic [BUS_WIDTH-1:0]    output_b,
  output logic [BUS_WIDTH-1:0]    output_c,
  output logic [BUS_WIDTH-1:0]    output_d,
  input  logic [BUS_WIDTH-1:0]    input_y,
  input  logic [BUS_WIDTH-1:0]    input_z,
  output logic                    overrun
);

  localparam int NB     = BUS_WIDTH / 8;
  localparam int SW     = (BUS_WIDTH > 32) ? BUS_WIDTH : 32;
  localparam int MAXLEN = (NB > 4) ? NB : 4;
  localparam int BC_W   = $clog2(MAXLEN + 1);
  localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

  state_t  state_q, state_d;
  target_t target_q, target_d;

  logic [BC_W-1:0]         bcnt_q, bcnt_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic [SW-1:0]           shreg_q, shreg_d;
  logic [SW-1:0]           sh_next;
  logic [1:0]              wr_sel_q, wr_sel_d;
  logic                    option_q, option_d;
  logic                    out_enable_q, out_enable_d;
  logic [COUNTER_BITS-1:0] divider_q, divider_d;
  logic                    pulse_q, pulse_d;
  logic                    overrun_q, overrun_d;
  logic [BUS_WIDTH-1:0]    out_q [4];
  logic [BUS_WIDTH-1:0]    out_d [4];
  logic                    wr_out_en;

  logic                    ld_word, ld_byte, ser_done;
  logic [BUS_WIDTH-1:0]    ld_word_data;
  logic [7:0]              ld_byte_data;

  logic                    last_byte;
  logic                    tmo_hit;
  logic [31:0]             div_word;
  logic [BUS_WIDTH-1:0]    wr_word;

  // Payload shifts in from the top, so after k bytes the first byte sits lowest
  // in the top 8*k bits; the final byte is folded in combinationally.
  assign sh_next   = {rx_data, shreg_q[SW-1:8]};
  assign div_word  = sh_next[SW-1 -: 32];
  assign wr_word   = sh_next[SW-1 -: BUS_WIDTH];
  assign last_byte = (state_q == ST_PAYLOAD) && rx_valid && (bcnt_q == BC_W'(1));
  assign tmo_hit   = (state_q == ST_PAYLOAD) && !rx_valid && (tmo_q >= TMO_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          if (payload_len(rx_data, NB) != 0) state_d = ST_PAYLOAD;
          else                               state_d = ST_RESP;
        end
      end
      ST_PAYLOAD: if (last_byte || tmo_hit) state_d = ST_RESP;
      ST_RESP:    if (ser_done) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    target_d     = target_q;
    bcnt_d       = bcnt_q;
    tmo_d        = tmo_q;
    shreg_d      = shreg_q;
    wr_sel_d     = wr_sel_q;
    option_d     = option_q;
    out_enable_d = out_enable_q;
    divider_d    = divider_q;
    pulse_d      = 1'b0;
    overrun_d    = overrun_q;
    wr_out_en    = 1'b0;
    ld_word      = 1'b0;
    ld_byte      = 1'b0;
    ld_word_data = '0;
    ld_byte_data = '0;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          bcnt_d   = BC_W'(payload_len(rx_data, NB));
          tmo_d    = '0;
          shreg_d  = '0;
          wr_sel_d = rx_data[1:0];
          case (rx_data)
            OP_SET_DIV:  target_d = TGT_DIV;
            OP_SET_CTRL: target_d = TGT_CTRL;
            OP_WR_A, OP_WR_B, OP_WR_C, OP_WR_D: target_d = TGT_OUT;
            OP_PULSE: begin
              pulse_d      = 1'b1;
              ld_byte      = 1'b1;
              ld_byte_data = ACK;
            end
            OP_RD_Y: begin
              ld_word      = 1'b1;
              ld_word_data = input_y;
            end
            OP_RD_Z: begin
              ld_word      = 1'b1;
              ld_word_data = input_z;
            end
            default: begin
              ld_byte      = 1'b1;
              ld_byte_data = NAK;
            end
          endcase
        end
      end
      ST_PAYLOAD: begin
        if (rx_valid) begin
          shreg_d = sh_next;
          tmo_d   = '0;
          if (bcnt_q != '0) bcnt_d = bcnt_q - BC_W'(1);
          if (last_byte) begin
            ld_byte      = 1'b1;
            ld_byte_data = ACK;
            case (target_q)
              TGT_DIV: divider_d = div_word[COUNTER_BITS-1:0];
              TGT_CTRL: begin
                option_d     = rx_data[0];
                out_enable_d = rx_data[1];
              end
              default: wr_out_en = 1'b1;
            endcase
          end
        end else if (tmo_hit) begin
          bcnt_d       = '0;
          ld_byte      = 1'b1;
          ld_byte_data = NAK;
        end else if (tmo_q < TMO_LIMIT) begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_RESP: if (rx_valid) overrun_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target_q     <= TGT_DIV;
      bcnt_q       <= '0;
      tmo_q        <= '0;
      shreg_q      <= '0;
      wr_sel_q     <= '0;
      option_q     <= 1'b0;
      out_enable_q <= 1'b0;
      divider_q    <= '0;
      pulse_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      target_q     <= target_d;
      bcnt_q       <= bcnt_d;
      tmo_q        <= tmo_d;
      shreg_q      <= shreg_d;
      wr_sel_q     <= wr_sel_d;
      option_q     <= option_d;
      out_enable_q <= out_enable_d;
      divider_q    <= divider_d;
      pulse_q      <= pulse_d;
      overrun_q    <= overrun_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_out
      assign out_d[gi] = (wr_out_en && (wr_sel_q == 2'(gi))) ? wr_word : out_q[gi];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) out_q[gi] <= '0;
        else       out_q[gi] <= out_d[gi];
      end
    end
  endgenerate

  debug_tx_serializer #(.NB(NB)) u_tx (
    .clk       (clk),
    .reset     (reset),
    .load_word (ld_word),
    .word_data (ld_word_data),
    .load_byte (ld_byte),
    .byte_data (ld_byte_data),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .done      (ser_done)
  );

  assign option     = option_q;
  assign out_enable = out_enable_q;
  assign divider    = divider_q;
  assign pulse      = pulse_q;
  assign overrun    = overrun_q;
  assign output_a   = out_q[0];
  assign output_b   = out_q[1];
  assign output_c   = out_q[2];
  assign output_d   = out_q[3];

endmodule

// File: tb/tb_debug_cmd_parser.sv
// Bench for debug_cmd_parser: directed scenarios followed by random command
// streams checked against a transaction-level register/response model.
module tb_debug_cmd_parser;

  localparam int BW  = 32;
  localparam int CB  = 32;
  localparam int TMO = 40;
  localparam int NB  = BW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          option;
  logic          out_enable;
  logic [CB-1:0] divider;
  logic          pulse;
  logic [BW-1:0] output_a, output_b, output_c, output_d;
  logic [BW-1:0] input_y, input_z;
  logic          overrun;

  debug_cmd_parser #(
    .BUS_WIDTH      (BW),
    .COUNTER_BITS   (CB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .option     (option),
    .out_enable (out_enable),
    .divider    (divider),
    .pulse      (pulse),
    .output_a   (output_a),
    .output_b   (output_b),
    .output_c   (output_c),
    .output_d   (output_d),
    .input_y    (input_y),
    .input_z    (input_z),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: architectural register values and expected response bytes.
  logic [CB-1:0] m_div;
  logic          m_opt, m_oe, m_ovr;
  logic [BW-1:0] m_out [4];
  logic [7:0]    exp_bytes [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic model_reset();
    m_div = '0; m_opt = 1'b0; m_oe = 1'b0; m_ovr = 1'b0;
    for (int i = 0; i < 4; i++) m_out[i] = '0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "/div"},     divider,    m_div);
    check({tag, "/opt"},     option,     m_opt);
    check({tag, "/oe"},      out_enable, m_oe);
    check({tag, "/out_a"},   output_a,   m_out[0]);
    check({tag, "/out_b"},   output_b,   m_out[1]);
    check({tag, "/out_c"},   output_c,   m_out[2]);
    check({tag, "/out_d"},   output_d,   m_out[3]);
    check({tag, "/overrun"}, overrun,    m_ovr);
  endtask

  // Drain the expected response with random backpressure, then confirm silence.
  task automatic expect_resp(input string tag);
    bit got;
    for (int i = 0; i < exp_bytes.size(); i++) begin
      got = 1'b0;
      for (int n = 0; n < 100 && !got; n++) begin
        tx_ready = ($urandom_range(0, 2) != 0);
        if (tx_valid && tx_ready) begin
          check({tag, "/byte"}, tx_data, exp_bytes[i]);
          got = 1'b1;
        end
        tick();
      end
      tx_ready = 1'b0;
      check({tag, "/handshake"}, got, 1);
    end
    tick();
    check({tag, "/no_extra"}, tx_valid, 0);
    $display("txn %s: %0d response byte(s)", tag, exp_bytes.size());
    exp_bytes = {};
  endtask

  task automatic send_payload(input logic [63:0] v, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) tick();
      send(v[8*i +: 8]);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [BW-1:0] v, z;
    logic [7:0]    d0, op;
    bit            seen;
    int            sel, idx;

    reset = 1'b1; rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0;
    input_y = '0; input_z = '0;
    exp_bytes = {};
    model_reset();
    repeat (3) tick();
    check("reset/tx_valid", tx_valid, 0);
    check("reset/tx_data",  tx_data,  0);
    check("reset/pulse",    pulse,    0);
    check_regs("reset");
    reset = 1'b0;
    tick();

    // SET_DIV: no partial update, then register and ACK visible together.
    send(8'h01); send(8'h78); send(8'h56); send(8'h34);
    check("div/partial", divider, 0);
    send(8'h12);
    check("div/value", divider, 32'h12345678);
    check("div/ack_latency", tx_valid, 1);
    m_div = 32'h12345678;
    exp_bytes.push_back(8'hAA);
    expect_resp("set_div");

    send(8'h02); send(8'h03);
    m_opt = 1'b1; m_oe = 1'b1;
    check("ctrl/opt", option, 1);
    check("ctrl/oe",  out_enable, 1);
    exp_bytes.push_back(8'hAA);
    expect_resp("set_ctrl");

    send(8'h03);
    check("pulse/high", pulse, 1);
    check("pulse/ack_valid", tx_valid, 1);
    tick();
    check("pulse/low", pulse, 0);
    exp_bytes.push_back(8'hAA);
    expect_resp("pulse");

    send(8'h12);
    send_payload(64'hDEADBEEF, 4, 1'b0);
    m_out[2] = 32'hDEADBEEF;
    check("wr_c/value", output_c, 32'hDEADBEEF);
    exp_bytes.push_back(8'hAA);
    expect_resp("write_c");

    input_y = 32'hCAFEBABE;
    send(8'h20);
    input_y = 32'h01234567;
    exp_bytes.push_back(8'hBE); exp_bytes.push_back(8'hBA);
    exp_bytes.push_back(8'hFE); exp_bytes.push_back(8'hCA);
    expect_resp("read_y");
    check_regs("after_read_y");

    // Backpressure during READ_Z with stray rx strobes (pulse opcodes) dropped.
    z = 32'h8877A5C3;
    input_z = z;
    send(8'h21);
    d0 = tx_data;
    check("bp/first_byte", d0, 8'hC3);
    for (int c = 0; c < 10; c++) begin
      if (c == 2 || c == 6) begin rx_data = 8'h03; rx_valid = 1'b1; end
      tick();
      rx_valid = 1'b0;
      check("bp/tx_valid", tx_valid, 1);
      check("bp/tx_data",  tx_data,  d0);
      check("bp/no_pulse", pulse,    0);
    end
    m_ovr = 1'b1;
    check("bp/overrun", overrun, 1);
    for (int i = 0; i < NB; i++) exp_bytes.push_back(z[8*i +: 8]);
    expect_resp("read_z_bp");
    check_regs("after_bp");

    // Timeout mid WRITE_A.
    send(8'h10); send(8'h11); send(8'h22);
    repeat (TMO - 1) tick();
    check("tmo/not_early", tx_valid, 0);
    seen = 1'b0;
    for (int n = 0; n < 6 && !seen; n++) begin
      if (tx_valid) seen = 1'b1;
      else tick();
    end
    check("tmo/fired", seen, 1);
    check("tmo/out_a", output_a, 0);
    exp_bytes.push_back(8'hEE);
    expect_resp("timeout");
    send(8'h10);
    send_payload(64'h0BADF00D, 4, 1'b1);
    m_out[0] = 32'h0BADF00D;
    exp_bytes.push_back(8'hAA);
    expect_resp("write_a_after_tmo");
    check_regs("after_tmo");

    send(8'h7F);
    exp_bytes.push_back(8'hEE);
    expect_resp("bad_op");

    // Asynchronous reset in the middle of a SET_DIV payload.
    send(8'h01); send(8'h44); send(8'h33);
    reset = 1'b1;
    #2;
    model_reset();
    check("arst/tx_valid", tx_valid, 0);
    check("arst/pulse",    pulse,    0);
    check_regs("arst");
    tick();
    reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      check("arst/silent", tx_valid, 0);
    end
    send(8'h03);
    check("arst/idle_pulse", pulse, 1);
    exp_bytes.push_back(8'hAA);
    expect_resp("post_reset_pulse");
    $display("txn reset_mid_payload: outputs cleared");

    // Random command stream against the model.
    for (int k = 0; k < 30; k++) begin
      sel = $urandom_range(0, 5);
      v   = $urandom;
      case (sel)
        0: begin
          send(8'h01); send_payload(64'(v), 4, 1'b1);
          m_div = v; exp_bytes.push_back(8'hAA);
        end
        1: begin
          send(8'h02); send_payload(64'(v[7:0]), 1, 1'b1);
          m_opt = v[0]; m_oe = v[1]; exp_bytes.push_back(8'hAA);
        end
        2: begin
          send(8'h03);
          check("rnd/pulse_high", pulse, 1);
          tick();
          check("rnd/pulse_low", pulse, 0);
          exp_bytes.push_back(8'hAA);
        end
        3: begin
          idx = $urandom_range(0, 3);
          send(8'h10 + 8'(idx)); send_payload(64'(v), NB, 1'b1);
          m_out[idx] = v; exp_bytes.push_back(8'hAA);
        end
        4: begin
          if (v[0]) begin input_z = v; send(8'h21); end
          else      begin input_y = v; send(8'h20); end
          input_y = $urandom; input_z = $urandom;
          for (int i = 0; i < NB; i++) exp_bytes.push_back(v[8*i +: 8]);
        end
        default: begin
          do op = 8'($urandom_range(0, 255));
          while (op inside {8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21});
          send(op);
          exp_bytes.push_back(8'hEE);
        end
      endcase
      expect_resp($sformatf("rnd%0d_sel%0d", k, sel));
      check_regs("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
